// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared definitions for the execute-stage multiply/divide unit:
//               FSM state encoding, iteration counts and the most negative
//               operand value. The optional macro MULTDIV_BOOTH_EN selects
//               radix-4 Booth multiplication, which halves the multiply
//               iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    // Datapath width the unit is built and verified at
    localparam int MD_WIDTH = 32;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Number of multiply iterations for a given operand width
    function automatic int mult_iters(input int width);
`ifdef MULTDIV_BOOTH_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

    localparam int ITER_MULT = mult_iters(MD_WIDTH);
    localparam int ITER_DIV  = MD_WIDTH;

    localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_counter
// Description : Iteration counter for the multiply/divide unit. Cleared by
//               i_load, advances while i_en is high, and flags o_last while
//               the count equals i_limit-1 (the final iteration).
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low clear
//               i_load   - restart the count at zero
//               i_en     - advance the count by one
//               i_limit  - number of iterations of the running operation
//               o_last   - current iteration is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == (i_limit - 1'b1));

endmodule : multdiv_counter
`default_nettype wire

// File: rtl/execute_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_multdiv
// Description : Iterative signed multiply/divide unit for the X stage.
//               A start pulse in IDLE captures the D/X operands; the unit
//               then iterates one multiplier bit (or one quotient bit) per
//               clock, raises data_resultRDY for one cycle in DONE and
//               returns to IDLE. busy stalls the upstream latches while the
//               unit iterates.
//               Multiply: radix-2 shift-add by default; radix-4 Booth when
//               MULTDIV_BOOTH_EN is defined (half the iterations, same
//               results).
//               Divide  : restoring division on magnitudes, quotient
//               truncated toward zero, remainder discarded.
// Ports       : clock          - rising-edge clock
//               reset          - asynchronous active-low reset
//               data_operandA  - multiplicand / dividend
//               data_operandB  - multiplier / divisor
//               ctrl_MULT      - start pulse, signed multiply (wins a tie)
//               ctrl_DIV       - start pulse, signed divide
//               data_result    - product low word / quotient
//               data_exception - multiply overflow, divide-by-zero or
//                                INT_MIN / -1
//               data_resultRDY - one-cycle result-valid pulse
//               busy           - unit is iterating
// Revision    : 1.0 - initial release
// ============================================================================
module execute_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int               PROD_W     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] c_lim_mult = CNT_W'(mult_iters(WIDTH));
    localparam logic [CNT_W-1:0] c_lim_div  = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_neg_one  = '1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [PROD_W-1:0] r_acc;       // running product
    logic [PROD_W-1:0] r_mcand;     // sign-extended multiplicand, shifted up
`ifdef MULTDIV_BOOTH_EN
    logic [WIDTH:0]    r_mplier;    // multiplier with a zero appended below bit 0
`else
    logic [WIDTH-1:0]  r_mplier;
`endif
    logic [WIDTH-1:0]  r_rem;       // partial remainder
    logic [WIDTH-1:0]  r_quo;       // dividend bits shifted out, quotient bits shifted in
    logic [WIDTH-1:0]  r_divisor;   // divisor magnitude
    logic              r_neg_q;     // quotient must be negated on completion
    logic              r_div_ovf;   // INT_MIN / -1 captured
    logic [WIDTH-1:0]  r_result;
    logic              r_exception;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic             w_start;
    logic             w_cnt_last;
    logic [CNT_W-1:0] w_limit;

    assign w_start = (r_state == ST_IDLE) && (ctrl_MULT || ctrl_DIV);
    assign busy    = (r_state == ST_MULT) || (r_state == ST_DIV);
    assign w_limit = (r_state == ST_MULT) ? c_lim_mult : c_lim_div;

    multdiv_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_start),
        .i_en    (busy),
        .i_limit (w_limit),
        .o_last  (w_cnt_last)
    );

    // ------------------------------------------------------------------
    // Multiply step
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] w_addend;
    logic [PROD_W-1:0] w_acc_next;
    logic [PROD_W-1:0] w_mcand_next;
    logic [WIDTH:0]    w_prod_hi;
    logic              w_mul_ovf;
`ifdef MULTDIV_BOOTH_EN
    logic [WIDTH:0]    w_mplier_next;
    logic [WIDTH:0]    w_mplier_init;

    assign w_mplier_init = {data_operandB, 1'b0};

    // Radix-4 Booth digit from the overlapping 3-bit window
    always_comb begin
        w_addend = '0;
        case (r_mplier[2:0])
            3'b001, 3'b010: w_addend = r_mcand;
            3'b011:         w_addend = {r_mcand[PROD_W-2:0], 1'b0};
            3'b100:         w_addend = -{r_mcand[PROD_W-2:0], 1'b0};
            3'b101, 3'b110: w_addend = -r_mcand;
            default:        w_addend = '0;
        endcase
    end

    assign w_mcand_next  = {r_mcand[PROD_W-3:0], 2'b00};
    assign w_mplier_next = {{2{r_mplier[WIDTH]}}, r_mplier[WIDTH:2]};
`else
    logic [WIDTH-1:0]  w_mplier_next;
    logic [WIDTH-1:0]  w_mplier_init;

    assign w_mplier_init = data_operandB;

    // The multiplier sign bit carries weight -2^(WIDTH-1), so the partial
    // product of the final iteration is subtracted rather than added.
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = w_cnt_last ? -r_mcand : r_mcand;
        end
    end

    assign w_mcand_next  = {r_mcand[PROD_W-2:0], 1'b0};
    assign w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};
`endif

    assign w_acc_next = r_acc + w_addend;
    // Product fits in WIDTH signed bits only if the upper half plus the
    // low-word sign bit are all copies of one value.
    assign w_prod_hi  = w_acc_next[PROD_W-1:WIDTH-1];
    assign w_mul_ovf  = !((&w_prod_hi) || !(|w_prod_hi));

    // ------------------------------------------------------------------
    // Divide step (restoring, on magnitudes)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_signed;

    // INT_MIN negates to itself, which is its correct unsigned magnitude
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign w_rem_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_diff   = w_rem_shift - {1'b0, r_divisor};
    // No borrow out of the subtraction means the divisor fits
    assign w_q_bit      = !w_rem_diff[WIDTH];
    assign w_rem_next   = w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next   = {r_quo[WIDTH-2:0], w_q_bit};
    assign w_quo_signed = r_neg_q ? -w_quo_next : w_quo_next;

    // ------------------------------------------------------------------
    // FSM and datapath update
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_neg_q     <= 1'b0;
            r_div_ovf   <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_MULT) begin
                        r_state  <= ST_MULT;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                        r_mplier <= w_mplier_init;
                    end else if (ctrl_DIV) begin
                        r_rem     <= '0;
                        r_quo     <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_div_ovf <= (data_operandA == c_int_min) &&
                                     (data_operandB == c_neg_one);
                        if (data_operandB == '0) begin
                            // Divide by zero: no iteration, flag it at once
                            r_state     <= ST_DONE;
                            r_result    <= '0;
                            r_exception <= 1'b1;
                        end else begin
                            r_state <= ST_DIV;
                        end
                    end
                end

                ST_MULT: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= w_mcand_next;
                    r_mplier <= w_mplier_next;
                    if (w_cnt_last) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_exception <= w_mul_ovf;
                    end
                end

                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (w_cnt_last) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_quo_signed;
                        r_exception <= r_div_ovf;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == ST_DONE);

endmodule : execute_multdiv
`default_nettype wire

// File: tb/tb_execute_multdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_multdiv
// Description : Self-checking bench for execute_multdiv. Expected results
//               come from a behavioural model and are queued at each start;
//               a monitor pops and compares them on every data_resultRDY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_multdiv;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    always #5 clock = ~clock;

    execute_multdiv #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

`ifdef MULTDIV_BOOTH_EN
    localparam int LAT_MULT = 16;
`else
    localparam int LAT_MULT = 32;
`endif
    localparam int LAT_DIV  = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   rdy_count = 0;
    int   n_pushed  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: full 64-bit product, overflow if it does not
    // fit in a signed 32-bit value.
    function automatic exp_t model_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        p     = longint'($signed(a)) * longint'($signed(b));
        e.res = p[31:0];
        e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return e;
    endfunction

    function automatic exp_t model_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            e.res = 32'(int'($signed(a)) / int'($signed(b)));
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin
        if (data_resultRDY) begin
            exp_t e;
            rdy_count++;
            check("rdy_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'b0, data_exception}, {31'b0, e.exc});
            end
        end
    end

    // Drive a start pulse; the following rising edge is the capture edge.
    // Operands are scrambled afterwards to show they are not re-sampled.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input bit push);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (push) begin
            q.push_back(m ? model_mul(a, b) : model_div(a, b));
            n_pushed++;
        end
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count falling edges after the capture edge until RDY is seen. exp_lat
    // is the number of rising edges between capture and RDY rising.
    task automatic wait_rdy(input string tag, input int exp_lat);
        int lat      = -1;
        int busy_bad = 0;
        bit seen     = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                seen = 1'b1;
                lat  = k;
                check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        check({tag, "_rdy_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_low_early"}, 32'(busy_bad), 32'd0);
        @(negedge clock);
        check({tag, "_rdy_one_cycle"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
        start_op(m, d, a, b, 1'b1);
        wait_rdy(tag, lat);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_result", data_result, 32'd0);
        check("rst_exception", {31'b0, data_exception}, 32'd0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Plan 1-4 plus a few extra sign combinations
        run_op("mul_7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, LAT_MULT);
        check("mul_7x-6_hold", data_result, 32'hFFFF_FFD6);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, LAT_MULT);
        run_op("div_-100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, LAT_DIV);
        check("div_-100/7_hold", data_result, 32'hFFFF_FFF2);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV);
        run_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
        run_op("mul_-7x-8", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF8, LAT_MULT);
        run_op("mul_minx-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, LAT_MULT);
        run_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, LAT_DIV);
        run_op("div_min/3", 1'b0, 1'b1, 32'h8000_0000, 32'd3, LAT_DIV);
        for (int i = 0; i < 3; i++) begin
            run_op("mul_rand", 1'b1, 1'b0, $urandom, $urandom, LAT_MULT);
            run_op("div_rand", 1'b0, 1'b1, $urandom, 32'($urandom_range(1, 100000)), LAT_DIV);
        end

        // Plan 6: both starts at once -> multiply; a DIV pulse mid-operation is ignored
        start_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1);
        repeat (5) @(negedge clock);
        data_operandA = 32'd100;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        wait_rdy("mul_div_tie", LAT_MULT - 6);
        check("tie_result", data_result, 32'd18);
        repeat (40) @(negedge clock);
        check("no_stray_rdy", 32'(rdy_count), 32'(n_pushed));

        // Plan 5: reset mid-multiply aborts with no RDY
        start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        repeat (9) @(negedge clock);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_exception", {31'b0, data_exception}, 32'd0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_rdy", 32'(rdy_count), 32'(n_pushed));
        run_op("mul_3x4", 1'b1, 1'b0, 32'd3, 32'd4, LAT_MULT);
        check("mul_3x4_hold", data_result, 32'd12);

        repeat (5) @(negedge clock);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("rdy_total", 32'(rdy_count), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_execute_multdiv
`default_nettype wire
